bicubic_tap_acc: RTL and testbench
==================================

// Module: bicubic_tap_acc
// PURPOSE
//  Consumer side of the bicubic tap multiplier: accepts a stream of sign-magnitude
//  tap products (8-bit magnitude + sign, already scaled by 1/128) and sums TAPS of
//  them into one interpolated pixel. Result is clamped to 0..255 and presented on a
//  valid/ready output. One instance per colour channel after the multiplier array.
// PARAMETERS
//  TAPS    4   products summed per output pixel (>=2)
//  ACC_W   12  signed accumulator width; must hold +/-TAPS*255 (>= clog2(TAPS*255)+2)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      tap product valid
//  in_ready    out  1      block can accept a tap this cycle
//  in_product  in   8      tap product magnitude
//  in_sign     in   1      tap product sign (1 = negative)
//  in_last     in   1      source marks final tap of group (checked, not used to close)
//  out_valid   out  1      out_pixel valid
//  out_ready   in   1      downstream accepts out_pixel
//  out_pixel   out  8      clamped interpolated pixel
//  out_clamped out  1      out_pixel was saturated (sum <0 or >255); valid with out_valid
//  err_last    out  1      sticky: in_last disagreed with internal tap count
// BEHAVIOUR
//  Reset (rst_n low, any time, async): acc=0, tap_cnt=0, out_valid=0, out_pixel=0,
//   out_clamped=0, err_last=0. Partial group is discarded; next accepted tap is tap 0.
//  Handshake: tap accepted when in_valid & in_ready. in_ready = ~out_valid | out_ready
//   (combinational from out_ready). Output transfer when out_valid & out_ready.
//   out_pixel/out_clamped held stable while out_valid & ~out_ready.
//  Signed conversion: term = in_sign ? -in_product : +in_product, sign-extended to
//   ACC_W. Negative zero (in_sign=1, in_product=0) contributes 0.
//  Counter tap_cnt: 0..TAPS-1, increments per accepted tap, wraps to 0 after TAPS-1.
//  Accumulate: on accepted tap with tap_cnt<TAPS-1: acc <= (tap_cnt==0 ? 0 : acc)+term.
//   Tap 0 always restarts the sum; no separate clear cycle.
//  Close: on accepted tap with tap_cnt==TAPS-1: sum = acc+term;
//   out_pixel <= sum<0 ? 0 : sum>255 ? 255 : sum[7:0]; out_clamped <= (sum<0|sum>255);
//   out_valid <= 1. Latency: out_valid high the cycle after the last tap is accepted.
//  Throughput: one tap per clock; a TAPS-tap group every TAPS cycles with out_ready=1.
//  Simultaneous: output transfer and acceptance of a tap in the same cycle is legal;
//   if that tap closes a new group, out_valid stays 1 with new data (no bubble);
//   otherwise out_valid <= 0.
//  Backpressure: out_valid & ~out_ready -> in_ready=0; acc/tap_cnt frozen, no tap lost.
//  in_last check: on accepted tap, if in_last != (tap_cnt==TAPS-1) set err_last=1;
//   sticky until reset. Grouping always follows tap_cnt, never in_last.
//  No internal overflow for legal ACC_W; parameter check via initial assertion in sim.
// TESTING
//  1 TAPS=4, taps +10,+100,+20,-5 back-to-back, out_ready=1 -> out_pixel=125,
//    out_clamped=0, out_valid one cycle after 4th tap, for exactly one cycle.
//  2 Clamp: taps -50,+10,+0,+5 -> out_pixel=0,out_clamped=1; taps +200,+100,+10,-0
//    -> out_pixel=255,out_clamped=1; negative zero adds nothing.
//  3 Backpressure: out_ready=0 after group close, keep in_valid=1 for 6 cycles ->
//    in_ready=0, out_pixel stable; release -> next group sums correctly, no tap lost.
//  4 Streaming: 8 groups back-to-back with out_ready=1 -> 8 outputs, one every 4
//    cycles, matching a software model incl. same-cycle transfer/close.
//  5 in_last asserted on tap 2 of a group -> err_last=1 and stays 1; pixel still
//    closes after tap 3 with the correct sum.
//  6 Assert rst_n low after 2 taps of a group -> outputs/err_last zero immediately;
//    after release, 4 fresh taps +1,+2,+3,+4 -> out_pixel=10.

Source files
------------

// File: rtl/bicubic_tap_acc.sv
// Sums TAPS sign-magnitude tap products into one clamped 8-bit pixel.
// Grouping follows an internal tap counter; in_last is only cross-checked into err_last.
module bicubic_tap_acc #(
    parameter int unsigned TAPS  = 4,
    parameter int unsigned ACC_W = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_product,
    input  logic       in_sign,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_pixel,
    output logic       out_clamped,
    output logic       err_last
);

    localparam int unsigned CNT_W = $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(255);

    if (TAPS < 2 || ACC_W < $clog2(TAPS * 255) + 2) begin : g_param_check
        $error("bicubic_tap_acc: TAPS must be >= 2 and ACC_W must hold +/-TAPS*255");
    end

    logic [CNT_W-1:0]        tap_cnt_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    out_valid_q;
    logic [7:0]              out_pixel_q;
    logic                    out_clamped_q;
    logic                    err_last_q;

    logic                    accept;
    logic                    is_last;
    logic signed [ACC_W-1:0] mag_ext;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] sum;
    logic                    sum_neg;
    logic                    sum_high;
    logic [7:0]              pix_clamped;

    always_comb begin
        in_ready    = ~out_valid_q | out_ready;
        accept      = in_valid & in_ready;
        is_last     = (tap_cnt_q == LAST_CNT);
        mag_ext     = $signed({{(ACC_W - 8){1'b0}}, in_product});
        // Negating a zero magnitude yields zero, so negative zero needs no special case.
        term        = in_sign ? -mag_ext : mag_ext;
        // Tap 0 restarts the sum, so no clear cycle is needed between groups.
        sum         = ((tap_cnt_q == '0) ? '0 : acc_q) + term;
        sum_neg     = (sum < 0);
        sum_high    = (sum > PIX_MAX);
        pix_clamped = sum_neg ? 8'd0 : (sum_high ? 8'd255 : sum[7:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_cnt_q     <= '0;
            acc_q         <= '0;
            out_valid_q   <= 1'b0;
            out_pixel_q   <= 8'd0;
            out_clamped_q <= 1'b0;
            err_last_q    <= 1'b0;
        end else begin
            if (accept) begin
                tap_cnt_q <= is_last ? '0 : tap_cnt_q + 1'b1;
                if (!is_last) begin
                    acc_q <= sum;
                end
                if (in_last != is_last) begin
                    err_last_q <= 1'b1;
                end
            end
            // A closing tap wins over a same-cycle transfer so the output never bubbles.
            if (accept && is_last) begin
                out_valid_q   <= 1'b1;
                out_pixel_q   <= pix_clamped;
                out_clamped_q <= sum_neg | sum_high;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pixel   = out_pixel_q;
    assign out_clamped = out_clamped_q;
    assign err_last    = err_last_q;

endmodule

// File: tb/tb_bicubic_tap_acc.sv
// Directed and randomized checks of bicubic_tap_acc against a group-sum reference model.
module tb_bicubic_tap_acc;

    localparam int TAPS = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_product;
    logic       in_sign;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pixel;
    logic       out_clamped;
    logic       err_last;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int model_taps[$];
    int exp_pix[$];
    int exp_clp[$];
    int obs_pix[$];
    int obs_clp[$];
    int obs_cyc[$];

    bicubic_tap_acc #(.TAPS(TAPS), .ACC_W(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .in_sign    (in_sign),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixel  (out_pixel),
        .out_clamped(out_clamped),
        .err_last   (err_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Inputs change 1 time unit after posedge, so the negedge sees what the next edge will use.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            obs_pix.push_back(int'(out_pixel));
            obs_clp.push_back(int'(out_clamped));
            obs_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_tap(input int mag, input bit sgn);
        int s = 0;
        model_taps.push_back(sgn ? -mag : mag);
        if (model_taps.size() == TAPS) begin
            foreach (model_taps[i]) s += model_taps[i];
            exp_pix.push_back(s < 0 ? 0 : (s > 255 ? 255 : s));
            exp_clp.push_back((s < 0 || s > 255) ? 1 : 0);
            model_taps.delete();
        end
    endfunction

    task automatic send_tap(input int mag, input bit sgn, input bit bad_last);
        int waited = 0;
        in_valid   = 1'b1;
        in_product = mag[7:0];
        in_sign    = sgn;
        in_last    = (model_taps.size() == TAPS - 1) ^ bad_last;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            waited++;
            if (waited > 50) break;
        end
        if (waited > 50) check("tap_accept_timeout", 32'd0, 32'd1);
        else model_tap(mag, sgn);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_count"}, obs_pix.size(), exp_pix.size());
        while (exp_pix.size() > 0 && obs_pix.size() > 0) begin
            check({tag, "_pixel"}, obs_pix.pop_front(), exp_pix.pop_front());
            check({tag, "_clamped"}, obs_clp.pop_front(), exp_clp.pop_front());
            void'(obs_cyc.pop_front());
        end
        exp_pix.delete();
        exp_clp.delete();
        obs_pix.delete();
        obs_clp.delete();
        obs_cyc.delete();
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_product = 8'd0;
        in_sign    = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_pixel", out_pixel, 0);
        check("reset_out_clamped", out_clamped, 0);
        check("reset_err_last", err_last, 0);
        check("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic group: latency of one cycle, valid for exactly one cycle.
        send_tap(10, 0, 0);
        send_tap(100, 0, 0);
        send_tap(20, 0, 0);
        send_tap(5, 1, 0);
        check("basic_valid_after_last", out_valid, 1);
        check("basic_pixel", out_pixel, 125);
        check("basic_clamped", out_clamped, 0);
        @(posedge clk);
        #1;
        check("basic_valid_one_cycle", out_valid, 0);
        drain("basic");

        // Clamping, including negative zero.
        send_tap(50, 1, 0);
        send_tap(10, 0, 0);
        send_tap(0, 0, 0);
        send_tap(5, 0, 0);
        check("clamp_low_pixel", out_pixel, 0);
        check("clamp_low_flag", out_clamped, 1);
        send_tap(200, 0, 0);
        send_tap(100, 0, 0);
        send_tap(10, 0, 0);
        send_tap(0, 1, 0);
        check("clamp_high_pixel", out_pixel, 255);
        check("clamp_high_flag", out_clamped, 1);
        drain("clamp");

        // Backpressure: held output blocks input; the stalled tap is accepted afterwards.
        out_ready = 1'b0;
        send_tap(30, 0, 0);
        send_tap(40, 0, 0);
        send_tap(50, 0, 0);
        send_tap(60, 0, 0);
        in_valid   = 1'b1;
        in_product = 8'd7;
        in_sign    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_pixel_stable", out_pixel, 180);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_tap(7, 0, 0);
        send_tap(8, 0, 0);
        send_tap(9, 0, 0);
        send_tap(4, 1, 0);
        drain("backpressure");
        check("no_err_last_yet", err_last, 0);

        // Randomized back-to-back streaming: one output every TAPS cycles.
        for (int g = 0; g < 8; g++) begin
            for (int t = 0; t < TAPS; t++) begin
                send_tap(int'($urandom_range(0, 255)), bit'($urandom % 2), 0);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("stream_count", obs_cyc.size(), 8);
        if (obs_cyc.size() >= 8) begin
            for (int i = 1; i < 8; i++) check("stream_spacing", obs_cyc[i] - obs_cyc[i-1], TAPS);
        end
        drain("stream");

        // in_last on the wrong tap: sticky error, grouping unaffected.
        send_tap(11, 0, 0);
        send_tap(22, 0, 0);
        send_tap(33, 0, 1);
        check("err_last_set", err_last, 1);
        send_tap(44, 0, 0);
        check("err_last_sticky", err_last, 1);
        check("err_group_pixel", out_pixel, 110);
        drain("errlast");
        check("err_last_still_set", err_last, 1);

        // Asynchronous reset mid-group discards the partial sum.
        send_tap(100, 0, 0);
        send_tap(90, 0, 0);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_pixel", out_pixel, 0);
        check("async_rst_err_last", err_last, 0);
        model_taps.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_tap(1, 0, 0);
        send_tap(2, 0, 0);
        send_tap(3, 0, 0);
        send_tap(4, 0, 0);
        check("post_rst_pixel", out_pixel, 10);
        drain("postreset");
        check("post_rst_err_last", err_last, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
